// File: rtl/tdc_tap_sweep_ctrl_if.sv
// Result-record handshake between the tap sweep controller and the UART
// report path.
//   master : drives result_valid / result_tap / result_count, samples result_ready
//   slave  : samples the record, drives result_ready
interface tdc_tap_sweep_ctrl_if #(
    parameter int SEL_W = 5,
    parameter int CNT_W = 9
);
    logic             result_valid;
    logic             result_ready;
    logic [SEL_W-1:0] result_tap;
    logic [CNT_W-1:0] result_count;

    modport master (
        output result_valid,
        output result_tap,
        output result_count,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_tap,
        input  result_count,
        output result_ready
    );
endinterface

// File: rtl/tdc_tap_sweep_ctrl.sv
// TDC delay-line tap sweep controller.
// Steps the 32:1 tap mux through every tap, waits for the select to settle,
// counts 2^SAMPLES_LOG2 sampled hits per tap and hands one record per tap to
// the report path. The select only changes between measurement windows.
//
// Ports:
//   clk10m      system clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle request to begin a full sweep (ignored while busy)
//   abort       synchronous abort of a sweep in SETTLE/ACCUM/REPORT
//   sample_stb  one strobe per TDC measurement
//   tap_hit     registered mux output, valid with sample_stb
//   tap_sel     mux select
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the last record transfers
//   res         result record handshake (master side)
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start, tap_sel = 0
// S_SETTLE | select just changed, down-counting SETTLE cycles
// S_ACCUM  | counting samples and hits for the current tap
// S_REPORT | record held on the result bus until accepted
// S_DONE   | done pulse, tap_sel back to 0
module tdc_tap_sweep_ctrl #(
    parameter int NTAPS        = 32,
    parameter int SEL_W        = 5,
    parameter int SAMPLES_LOG2 = 8,
    parameter int CNT_W        = SAMPLES_LOG2 + 1,
    parameter int SETTLE       = 4
) (
    input  logic                      clk10m,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      sample_stb,
    input  logic                      tap_hit,
    output logic [SEL_W-1:0]          tap_sel,
    output logic                      busy,
    output logic                      done,
    tdc_tap_sweep_ctrl_if.master      res
);

    localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [ST_W-1:0]  SETTLE_LOAD = ST_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << SAMPLES_LOG2) - 1);
    localparam logic [SEL_W-1:0] LAST_TAP    = SEL_W'(NTAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_REPORT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [SEL_W-1:0] tap_q;
    logic [ST_W-1:0]  settle_q;
    logic [CNT_W-1:0] samp_q;
    logic [CNT_W-1:0] hit_q;
    logic [SEL_W-1:0] res_tap_q;
    logic [CNT_W-1:0] res_cnt_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             abort_now;

    // abort only acts while a tap is being measured or reported
    assign abort_now = abort &&
                       ((state_q == S_SETTLE) || (state_q == S_ACCUM) || (state_q == S_REPORT));

    always_ff @(posedge clk10m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tap_q     <= '0;
            settle_q  <= '0;
            samp_q    <= '0;
            hit_q     <= '0;
            res_tap_q <= '0;
            res_cnt_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_now) begin
                // a record accepted in this same cycle counts as delivered;
                // nothing more is needed for it
                state_q <= S_IDLE;
                tap_q   <= '0;
                samp_q  <= '0;
                hit_q   <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q  <= S_SETTLE;
                            tap_q    <= '0;
                            settle_q <= SETTLE_LOAD;
                            busy_q   <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_q == '0) begin
                            state_q <= S_ACCUM;
                            samp_q  <= '0;
                            hit_q   <= '0;
                        end else begin
                            settle_q <= settle_q - ST_W'(1);
                        end
                    end
                    S_ACCUM: begin
                        if (sample_stb) begin
                            samp_q <= samp_q + CNT_W'(1);
                            if (tap_hit) begin
                                hit_q <= hit_q + CNT_W'(1);
                            end
                            // the closing strobe is included in the record
                            if (samp_q == LAST_SAMPLE) begin
                                state_q   <= S_REPORT;
                                res_tap_q <= tap_q;
                                res_cnt_q <= hit_q + CNT_W'(tap_hit);
                                valid_q   <= 1'b1;
                            end
                        end
                    end
                    S_REPORT: begin
                        if (valid_q && res.result_ready) begin
                            valid_q <= 1'b0;
                            if (tap_q == LAST_TAP) begin
                                state_q <= S_DONE;
                                tap_q   <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q  <= S_SETTLE;
                                tap_q    <= tap_q + SEL_W'(1);
                                settle_q <= SETTLE_LOAD;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        tap_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tap_sel          = tap_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign res.result_valid = valid_q;
    assign res.result_tap   = res_tap_q;
    assign res.result_count = res_cnt_q;

endmodule

// File: tb/tb_tdc_tap_sweep_ctrl.sv
// Self-checking bench for tdc_tap_sweep_ctrl: table of sweep scenarios plus
// hand-written abort / start-while-busy / reset sequences.
module tb_tdc_tap_sweep_ctrl;

    localparam int NTAPS        = 32;
    localparam int SEL_W        = 5;
    localparam int SAMPLES_LOG2 = 8;
    localparam int CNT_W        = 9;
    localparam int SETTLE       = 4;

    logic             clk10m = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             sample_stb = 1'b0;
    logic             tap_hit = 1'b0;
    logic [SEL_W-1:0] tap_sel;
    logic             busy;
    logic             done;

    tdc_tap_sweep_ctrl_if #(.SEL_W(SEL_W), .CNT_W(CNT_W)) rif ();

    tdc_tap_sweep_ctrl #(
        .NTAPS(NTAPS), .SEL_W(SEL_W), .SAMPLES_LOG2(SAMPLES_LOG2),
        .CNT_W(CNT_W), .SETTLE(SETTLE)
    ) dut (
        .clk10m    (clk10m),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .sample_stb(sample_stb),
        .tap_hit   (tap_hit),
        .tap_sel   (tap_sel),
        .busy      (busy),
        .done      (done),
        .res       (rif)
    );

    always #50 clk10m = ~clk10m;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mode: 0 = always hit, 1 = hit only on taps >= 16, 2 = alternate per strobe
    typedef struct {
        string name;
        int    mode;
        int    stb_per;
        int    stall_tap;
        int    stall_cyc;
        int    exp_lo;     // expected count, taps 0..15
        int    exp_hi;     // expected count, taps 16..31
    } sweep_t;

    sweep_t vec[3];

    task automatic check_all_zero(input string tag);
        check({tag, " tap_sel"}, 32'(tap_sel), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " valid"}, 32'(rif.result_valid), 0);
        check({tag, " rtap"}, 32'(rif.result_tap), 0);
        check({tag, " rcount"}, 32'(rif.result_count), 0);
    endtask

    task automatic wait_tap(input int target, input int budget, input string tag);
        int n = 0;
        while (int'(tap_sel) != target && n < budget) begin
            @(negedge clk10m);
            n++;
        end
        if (n >= budget) check({tag, " wait_tap timeout"}, 32'(tap_sel), target);
    endtask

    task automatic run_sweep(input sweep_t v);
        int recs = 0;
        int dones = 0;
        int cyc = 0;
        int stall_left;
        int exp_cnt;
        logic alt = 1'b0;
        logic xfer_prev = 1'b0;
        logic done_prev = 1'b0;
        logic [SEL_W-1:0] prev_sel;
        bit finished = 0;
        stall_left = v.stall_cyc;
        rif.result_ready = 1'b1;
        @(negedge clk10m);
        start = 1'b1;
        @(negedge clk10m);
        start = 1'b0;
        check({v.name, " busy after start"}, 32'(busy), 1);
        check({v.name, " tap_sel after start"}, 32'(tap_sel), 0);
        prev_sel = tap_sel;
        while (!finished && cyc < 40000) begin
            // select may only move right after a record transfer
            if (tap_sel != prev_sel)
                check({v.name, " tap_sel step"}, 32'(tap_sel),
                      xfer_prev ? ((int'(prev_sel) == NTAPS-1) ? 0 : int'(prev_sel) + 1)
                                : int'(prev_sel));
            prev_sel = tap_sel;
            xfer_prev = 1'b0;
            if (done_prev) begin
                check({v.name, " busy after done"}, 32'(busy), 0);
                check({v.name, " done width"}, 32'(done), 0);
                check({v.name, " done count"}, 32'(dones), 1);
                check({v.name, " tap_sel idle"}, 32'(tap_sel), 0);
                finished = 1;
            end else begin
                if (done) begin
                    dones++;
                    check({v.name, " busy with done"}, 32'(busy), 1);
                    check({v.name, " records at done"}, 32'(recs), NTAPS);
                end
                done_prev = done;
                rif.result_ready = 1'b1;
                if (rif.result_valid) begin
                    if (int'(rif.result_tap) == v.stall_tap && stall_left > 0) begin
                        rif.result_ready = 1'b0;
                        stall_left--;
                        exp_cnt = (v.stall_tap < 16) ? v.exp_lo : v.exp_hi;
                        check({v.name, " stall rtap"}, 32'(rif.result_tap), v.stall_tap);
                        check({v.name, " stall rcount"}, 32'(rif.result_count), exp_cnt);
                        check({v.name, " stall tap_sel"}, 32'(tap_sel), v.stall_tap);
                    end else begin
                        exp_cnt = (recs < 16) ? v.exp_lo : v.exp_hi;
                        check({v.name, " rtap"}, 32'(rif.result_tap), recs);
                        check({v.name, " rcount"}, 32'(rif.result_count), exp_cnt);
                        recs++;
                        xfer_prev = 1'b1;
                    end
                end
                sample_stb = ((cyc % v.stb_per) == 0);
                case (v.mode)
                    0: tap_hit = 1'b1;
                    1: tap_hit = (int'(tap_sel) >= 16);
                    default: begin
                        tap_hit = alt;
                        if (sample_stb) alt = ~alt;
                    end
                endcase
                @(negedge clk10m);
                cyc++;
            end
        end
        if (!finished) check({v.name, " sweep timeout"}, 32'(recs), NTAPS);
        sample_stb = 1'b0;
        tap_hit = 1'b0;
    endtask

    sweep_t plain;
    int     dcount;

    initial begin
        vec[0] = '{name: "all_hit",  mode: 0, stb_per: 2, stall_tap: -1, stall_cyc: 0,  exp_lo: 256, exp_hi: 256};
        vec[1] = '{name: "half_hit", mode: 1, stb_per: 1, stall_tap: 3,  stall_cyc: 50, exp_lo: 0,   exp_hi: 256};
        vec[2] = '{name: "alt_hit",  mode: 2, stb_per: 1, stall_tap: -1, stall_cyc: 0,  exp_lo: 128, exp_hi: 128};
        plain  = '{name: "resweep",  mode: 0, stb_per: 1, stall_tap: -1, stall_cyc: 0,  exp_lo: 256, exp_hi: 256};

        rif.result_ready = 1'b0;
        repeat (3) @(negedge clk10m);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk10m);
        check_all_zero("post-reset");

        // abort alone in IDLE does nothing
        abort = 1'b1;
        @(negedge clk10m);
        abort = 1'b0;
        check("abort idle busy", 32'(busy), 0);

        // start and abort together in IDLE: start wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk10m);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", 32'(busy), 1);
        check("start+abort tap_sel", 32'(tap_sel), 0);
        abort = 1'b1;
        @(negedge clk10m);
        abort = 1'b0;
        check("abort settle busy", 32'(busy), 0);

        for (int i = 0; i < 3; i++) run_sweep(vec[i]);

        // abort at tap 5 in the middle of ACCUM
        sample_stb = 1'b1;
        tap_hit = 1'b1;
        rif.result_ready = 1'b1;
        start = 1'b1;
        @(negedge clk10m);
        start = 1'b0;
        wait_tap(5, 3000, "abort");
        repeat (SETTLE + 50) @(negedge clk10m);
        check("pre-abort busy", 32'(busy), 1);
        abort = 1'b1;
        @(negedge clk10m);
        abort = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort tap_sel", 32'(tap_sel), 0);
        check("abort valid", 32'(rif.result_valid), 0);
        check("abort done", 32'(done), 0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk10m);
            if (done || busy) dcount++;
        end
        check("abort quiet", 32'(dcount), 0);
        run_sweep(plain);

        // start while busy at tap 10, then async reset at tap 20
        sample_stb = 1'b1;
        tap_hit = 1'b1;
        rif.result_ready = 1'b1;
        start = 1'b1;
        @(negedge clk10m);
        start = 1'b0;
        wait_tap(10, 6000, "busy start");
        repeat (20) @(negedge clk10m);
        start = 1'b1;
        @(negedge clk10m);
        start = 1'b0;
        check("busy start tap_sel", 32'(tap_sel), 10);
        check("busy start busy", 32'(busy), 1);
        wait_tap(20, 6000, "reset");
        repeat (SETTLE + 30) @(negedge clk10m);
        #20;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        sample_stb = 1'b0;
        tap_hit = 1'b0;
        repeat (2) @(negedge clk10m);
        rst_n = 1'b1;
        @(negedge clk10m);
        check_all_zero("after reset");
        run_sweep(plain);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
